// File: rtl/leaf_out_arbiter.sv
// Round-robin packet scheduler from user output streams onto the leaf-to-BFT link.
// Adds destination/address headers and tracks per-stream receiver credit.
module leaf_out_arbiter #(
  parameter int NUM_OUT_PORTS = 3,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int PACKET_BITS   = 49
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
  input  logic                                    out_ready,
  input  logic                                    cfg_we,
  input  logic [2:0]                              cfg_port,
  input  logic                                    cfg_en,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
  input  logic                                    credit_vld,
  input  logic [2:0]                              credit_port,
  input  logic [NUM_ADDR_BITS:0]                  credit_cnt,
  output logic                                    credit_err
);

  localparam int CW = NUM_ADDR_BITS + 1;
  localparam int SW = NUM_ADDR_BITS + 2;
  localparam logic [CW-1:0] CMAX = CW'(2 ** NUM_ADDR_BITS);

  logic [NUM_OUT_PORTS-1:0] en_q;
  logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] port_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_q [NUM_OUT_PORTS];
  logic [2:0]               last_q;
  logic [PACKET_BITS-1:0]   dout_q;
  logic                     err_q;

  logic                     can_load;
  logic [NUM_OUT_PORTS-1:0] elig;
  logic                     gnt_vld;
  logic [2:0]               gnt_idx;
  logic [NUM_OUT_PORTS-1:0] gnt;
  logic [PACKET_BITS-1:0]   pkt;
  logic [NUM_OUT_PORTS-1:0] cfg_hit;
  logic [NUM_OUT_PORTS-1:0] ovf;
  logic [SW-1:0]            csum     [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_d [NUM_OUT_PORTS];

  assign dout_leaf_interface2bft = dout_q;
  assign credit_err = err_q;
  assign ack_interface2user = gnt;

  // Search order starts just after the last granted stream.
  always_comb begin
    can_load = !dout_q[PACKET_BITS-1] || out_ready;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      elig[i] = en_q[i] && vld_user2interface[i]
             && (credit_q[i] != '0);
    end
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (!gnt_vld && elig[i]
            && i == (int'(last_q) + k) % NUM_OUT_PORTS) begin
          gnt_vld = 1'b1;
          gnt_idx = 3'(i);
        end
      end
    end
    if (!can_load) gnt_vld = 1'b0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      gnt[i] = gnt_vld && (gnt_idx == 3'(i));
    end
  end

  always_comb begin
    pkt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (gnt[i]) begin
        pkt = {1'b1, leaf_q[i], port_q[i], addr_q[i],
               din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  // Net credit: return and consume land in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      cfg_hit[i] = cfg_we && (cfg_port == 3'(i));
      csum[i] = SW'(credit_q[i]);
      if (credit_vld && credit_port == 3'(i)) begin
        csum[i] = csum[i] + SW'(credit_cnt);
      end
      if (gnt[i]) csum[i] = csum[i] - SW'(1);
      ovf[i] = csum[i] > SW'(CMAX);
      credit_d[i] = ovf[i] ? CMAX : csum[i][CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= '0;
      last_q <= 3'(NUM_OUT_PORTS - 1);
      dout_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]   <= '0;
        port_q[i]   <= '0;
        addr_q[i]   <= '0;
        credit_q[i] <= CMAX;
      end
    end else begin
      if (can_load) begin
        if (gnt_vld) begin
          dout_q <= pkt;
          last_q <= gnt_idx;
        end else begin
          dout_q[PACKET_BITS-1] <= 1'b0;
        end
      end
      if (|(ovf & ~cfg_hit)) err_q <= 1'b1;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (cfg_hit[i]) begin
          en_q[i]     <= cfg_en;
          leaf_q[i]   <= cfg_dest_leaf;
          port_q[i]   <= cfg_dest_port;
          addr_q[i]   <= '0;
          credit_q[i] <= CMAX;
        end else begin
          credit_q[i] <= credit_d[i];
          if (gnt[i]) addr_q[i] <= addr_q[i] + NUM_ADDR_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Scoreboard bench for leaf_out_arbiter: a behavioural model predicts acks
// and the next output packet each cycle.
module tb_leaf_out_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [95:0] din = '0;
  logic [2:0]  vld = '0;
  logic [2:0]  ack;
  logic [48:0] dout;
  logic        out_ready = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_port = '0;
  logic        cfg_en = 1'b0;
  logic [4:0]  cfg_leaf = '0;
  logic [3:0]  cfg_dport = '0;
  logic        credit_vld = 1'b0;
  logic [2:0]  credit_port = '0;
  logic [7:0]  credit_cnt = '0;
  logic        credit_err;

  leaf_out_arbiter dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .dout_leaf_interface2bft (dout),
    .out_ready               (out_ready),
    .cfg_we                  (cfg_we),
    .cfg_port                (cfg_port),
    .cfg_en                  (cfg_en),
    .cfg_dest_leaf           (cfg_leaf),
    .cfg_dest_port           (cfg_dport),
    .credit_vld              (credit_vld),
    .credit_port             (credit_port),
    .credit_cnt              (credit_cnt),
    .credit_err              (credit_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  bit          m_en   [3];
  logic [4:0]  m_leaf [3];
  logic [3:0]  m_port [3];
  logic [6:0]  m_addr [3];
  int          m_cred [3];
  int          m_lg;
  logic [48:0] m_dout;
  bit          m_err;
  logic [48:0] sb [$];

  logic [2:0]  obs_ack, exp_ack;
  logic [48:0] obs_dout, exp_dout, held;
  logic        obs_err;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_en[i] = 0; m_leaf[i] = '0; m_port[i] = '0;
      m_addr[i] = '0; m_cred[i] = 128;
    end
    m_lg = 2; m_dout = '0; m_err = 0;
    sb.delete();
  endfunction

  function automatic logic [2:0] model_eval();
    logic [2:0] a;
    a = '0;
    if (!m_dout[48] || out_ready) begin
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (m_lg + k) % 3;
        if (a == 0 && m_en[i] && vld[i] && m_cred[i] != 0) a[i] = 1'b1;
      end
    end
    return a;
  endfunction

  function automatic void model_commit(input logic [2:0] a);
    bit load;
    int g;
    load = !m_dout[48] || out_ready;
    g = -1;
    for (int i = 0; i < 3; i++) if (a[i]) g = i;
    if (load) begin
      if (g >= 0) begin
        m_dout = {1'b1, m_leaf[g], m_port[g], m_addr[g], din[g*32 +: 32]};
        m_addr[g] = m_addr[g] + 7'd1;
        m_cred[g] = m_cred[g] - 1;
        m_lg = g;
      end else begin
        m_dout[48] = 1'b0;
      end
    end
    if (credit_vld && credit_port < 3
        && !(cfg_we && cfg_port == credit_port)) begin
      m_cred[credit_port] = m_cred[credit_port] + int'(credit_cnt);
      if (m_cred[credit_port] > 128) begin
        m_cred[credit_port] = 128;
        m_err = 1;
      end
    end
    if (cfg_we && cfg_port < 3) begin
      m_en[cfg_port] = cfg_en;
      m_leaf[cfg_port] = cfg_leaf;
      m_port[cfg_port] = cfg_dport;
      m_addr[cfg_port] = '0;
      m_cred[cfg_port] = 128;
    end
    sb.push_back(m_dout);
  endfunction

  // One clock: sample ack mid-cycle, then the registered packet after the edge.
  task automatic step();
    @(negedge clk);
    obs_ack = ack;
    exp_ack = model_eval();
    model_commit(exp_ack);
    @(posedge clk);
    #1;
    obs_dout = dout;
    obs_err = credit_err;
    exp_dout = sb.pop_front();
  endtask

  task automatic set_cfg(input logic [2:0] p, input logic e,
                         input logic [4:0] l, input logic [3:0] pt);
    cfg_we = 1'b1; cfg_port = p; cfg_en = e;
    cfg_leaf = l; cfg_dport = pt;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    vld = 3'b111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (dout !== 49'd0) begin
      n_fail++; $display("FAIL reset_dout got=%h want=0", dout);
    end
    n_chk++;
    if (ack !== 3'b000) begin
      n_fail++; $display("FAIL reset_ack got=%b want=000", ack);
    end
    n_chk++;
    if (credit_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got=%b want=0", credit_err);
    end
    reset_n = 1'b1;
    step();
    n_chk++;
    if (obs_ack !== 3'b000) begin
      n_fail++; $display("FAIL reset_noen_ack got=%b want=000", obs_ack);
    end
    vld = '0;
  endtask

  task automatic test_single_stream();
    logic [48:0] want;
    set_cfg(3'd0, 1'b1, 5'd5, 4'd2);
    vld = 3'b001;
    for (int k = 0; k < 3; k++) begin
      din[31:0] = 32'hA + 32'(k);
      step();
      want = {1'b1, 5'd5, 4'd2, 7'(k), 32'hA + 32'(k)};
      n_chk++;
      if (obs_ack !== 3'b001) begin
        n_fail++; $display("FAIL single_ack%0d got=%b want=001", k, obs_ack);
      end
      n_chk++;
      if (obs_dout !== want) begin
        n_fail++; $display("FAIL single_pkt%0d got=%h want=%h", k, obs_dout, want);
      end
    end
    vld = '0;
    step();
    n_chk++;
    if (obs_dout[48] !== 1'b0 || obs_dout !== exp_dout) begin
      n_fail++; $display("FAIL single_idle got=%h want=%h", obs_dout, exp_dout);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] rr [6];
    rr = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    set_cfg(3'd1, 1'b1, 5'd3, 4'd1);
    set_cfg(3'd2, 1'b1, 5'd7, 4'd9);
    vld = 3'b111;
    for (int c = 0; c < 6; c++) begin
      din = {32'h2000 + 32'(c), 32'h1000 + 32'(c), 32'h0000 + 32'(c)};
      step();
      n_chk++;
      if (obs_ack !== rr[c]) begin
        n_fail++; $display("FAIL rr_ack%0d got=%b want=%b", c, obs_ack, rr[c]);
      end
      n_chk++;
      if (obs_dout !== exp_dout) begin
        n_fail++; $display("FAIL rr_pkt%0d got=%h want=%h", c, obs_dout, exp_dout);
      end
    end
    vld = '0;
    step();
  endtask

  task automatic test_credit();
    set_cfg(3'd0, 1'b0, 5'd0, 4'd0);
    set_cfg(3'd2, 1'b0, 5'd0, 4'd0);
    set_cfg(3'd1, 1'b1, 5'd4, 4'd3);
    vld = 3'b010;
    for (int c = 0; c < 128; c++) begin
      din[63:32] = 32'(c);
      step();
      n_chk++;
      if (obs_ack !== 3'b010 || obs_dout !== exp_dout) begin
        n_fail++;
        $display("FAIL credit_beat%0d ack=%b pkt=%h want=010 %h",
                 c, obs_ack, obs_dout, exp_dout);
      end
    end
    step();
    n_chk++;
    if (obs_ack !== 3'b000) begin
      n_fail++; $display("FAIL credit_empty got=%b want=000", obs_ack);
    end
    credit_vld = 1'b1; credit_port = 3'd1; credit_cnt = 8'd4;
    din[63:32] = 32'hC0DE;
    step();
    credit_vld = 1'b0;
    n_chk++;
    if (obs_ack !== 3'b000) begin
      n_fail++; $display("FAIL credit_same_cycle got=%b want=000", obs_ack);
    end
    step();
    n_chk++;
    if (obs_ack !== 3'b010) begin
      n_fail++; $display("FAIL credit_next_cycle got=%b want=010", obs_ack);
    end
    n_chk++;
    if (obs_dout[48] !== 1'b1 || obs_dout[38:32] !== 7'd0) begin
      n_fail++; $display("FAIL credit_wrap pkt=%h want addr=0 valid", obs_dout);
    end
    vld = '0;
    step();
  endtask

  task automatic test_backpressure();
    set_cfg(3'd1, 1'b1, 5'd4, 4'd3);
    vld = 3'b010;
    din[63:32] = 32'hBEEF0000;
    step();
    held = exp_dout;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      din[63:32] = 32'hBEEF0001 + 32'(c);
      step();
      n_chk++;
      if (obs_ack !== 3'b000) begin
        n_fail++; $display("FAIL bp_ack%0d got=%b want=000", c, obs_ack);
      end
      n_chk++;
      if (obs_dout !== held || obs_dout !== exp_dout) begin
        n_fail++; $display("FAIL bp_hold%0d got=%h want=%h", c, obs_dout, held);
      end
    end
    out_ready = 1'b1;
    step();
    n_chk++;
    if (obs_ack !== 3'b010) begin
      n_fail++; $display("FAIL bp_release_ack got=%b want=010", obs_ack);
    end
    n_chk++;
    if (obs_dout !== exp_dout || obs_dout[38:32] !== 7'd1) begin
      n_fail++; $display("FAIL bp_release_pkt got=%h want=%h", obs_dout, exp_dout);
    end
    vld = '0;
    step();
  endtask

  task automatic test_credit_overflow();
    set_cfg(3'd1, 1'b1, 5'd4, 4'd3);
    n_chk++;
    if (obs_err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_pre got=%b want=0", obs_err);
    end
    credit_vld = 1'b1; credit_port = 3'd1; credit_cnt = 8'd1;
    step();
    credit_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      if (obs_err !== 1'b1 || obs_err !== m_err) begin
        n_fail++; $display("FAIL ovf_sticky%0d got=%b want=1", c, obs_err);
      end
      step();
    end
    vld = 3'b010;
    step();
    n_chk++;
    if (obs_ack !== 3'b010 || obs_dout !== exp_dout) begin
      n_fail++; $display("FAIL ovf_send ack=%b pkt=%h want=010 %h",
                         obs_ack, obs_dout, exp_dout);
    end
    vld = '0;
    step();
  endtask

  task automatic test_reset_midburst();
    set_cfg(3'd0, 1'b1, 5'd5, 4'd2);
    set_cfg(3'd1, 1'b1, 5'd6, 4'd1);
    vld = 3'b011;
    for (int c = 0; c < 3; c++) begin
      din = {32'h0, 32'h7700 + 32'(c), 32'h6600 + 32'(c)};
      step();
      n_chk++;
      if (obs_ack !== exp_ack || obs_dout !== exp_dout) begin
        n_fail++; $display("FAIL burst%0d ack=%b pkt=%h want=%b %h",
                           c, obs_ack, obs_dout, exp_ack, exp_dout);
      end
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (dout !== 49'd0 || ack !== 3'b000 || credit_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset dout=%h ack=%b err=%b want=0 000 0",
                         dout, ack, credit_err);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    n_chk++;
    if (obs_ack !== 3'b000) begin
      n_fail++; $display("FAIL midreset_disabled got=%b want=000", obs_ack);
    end
    set_cfg(3'd1, 1'b1, 5'd6, 4'd1);
    step();
    n_chk++;
    if (obs_ack !== 3'b010) begin
      n_fail++; $display("FAIL midreset_ack got=%b want=010", obs_ack);
    end
    n_chk++;
    if (obs_dout !== {1'b1, 5'd6, 4'd1, 7'd0, 32'h7702}) begin
      n_fail++; $display("FAIL midreset_pkt got=%h want addr 0", obs_dout);
    end
    vld = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_credit();
    test_backpressure();
    test_credit_overflow();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
